uart_rx_fifo: RTL and testbench

8N1 UART receiver, the receive-side counterpart to the existing UART_TX; same CLKS_PER_BIT convention (clk freq / baud).
- Synchronises the serial input, validates the start bit at mid-bit, samples 8 data bits LSB-first and checks the stop bit.
- Accepted bytes are buffered in a small show-ahead FIFO with a valid/ready pop interface, so the system controller can drain bytes at its own pace.

---
 rtl/uart_rx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver with mid-bit sampling and a show-ahead
//            valid/ready receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                             i_Clock,
   input  logic                             rst,
   input  logic                             i_RX_Serial,
   output logic [7:0]                       o_RX_Byte,
   output logic                             o_RX_Valid,
   input  logic                             i_RX_Ready,
   output logic                             o_Frame_Err,
   output logic                             o_Overrun,
   output logic                             o_RX_Busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_Count
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] c_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [OCC_W-1:0] c_FULL = OCC_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic             r_rx_meta;
   logic             r_rx_s;
   state_t           r_state,   w_state_nxt;
   logic [CNT_W-1:0] r_clk_cnt, w_cnt_nxt;
   logic [2:0]       r_bit_idx, w_idx_nxt;
   logic [7:0]       r_shift,   w_shift_nxt;
   logic             w_push;
   logic             w_frame_err;
   logic             w_overrun;

   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [OCC_W-1:0] r_count;
   logic             w_pop;
   logic             w_can_accept;

   assign w_pop        = (r_count != '0) && i_RX_Ready;
   // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
   assign w_can_accept = (r_count != c_FULL) || w_pop;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_clk_cnt;
      w_idx_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_push      = 1'b0;
      w_frame_err = 1'b0;
      w_overrun   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (!r_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_clk_cnt == c_HALF) begin
               w_cnt_nxt   = '0;
               w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end else begin
               w_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (r_clk_cnt == c_LAST) begin
               w_cnt_nxt              = '0;
               w_shift_nxt[r_bit_idx] = r_rx_s;
               if (r_bit_idx < 3'd7) begin
                  w_idx_nxt = r_bit_idx + 3'd1;
               end else begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_STOP;
               end
            end else begin
               w_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (r_clk_cnt == c_LAST) begin
               w_cnt_nxt = '0;
               if (r_rx_s) begin
                  w_push      = w_can_accept;
                  w_overrun   = !w_can_accept;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_frame_err = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end else begin
               w_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
         end
         S_BREAK: begin
            // Held-low line must return high before another frame is considered.
            w_cnt_nxt = '0;
            if (r_rx_s) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_rx_meta <= i_RX_Serial;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_cnt_nxt;
         r_bit_idx <= w_idx_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - OCC_W'(1);
      end
   end

   assign o_RX_Byte   = r_mem[r_rd_ptr];
   assign o_RX_Valid  = (r_count != '0);
   assign o_Count     = r_count;
   assign o_Frame_Err = w_frame_err;
   assign o_Overrun   = w_overrun;
   assign o_RX_Busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo (8 clocks/bit,
//            4-entry FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_serial;
   logic       rx_ready;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       rx_busy;
   logic [2:0] count;

   int n_cmp = 0;
   int n_err = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int both_cnt = 0;
   int fe_base;
   int ov_base;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .i_Clock     (clk),
      .rst         (rst),
      .i_RX_Serial (rx_serial),
      .o_RX_Byte   (rx_byte),
      .o_RX_Valid  (rx_valid),
      .i_RX_Ready  (rx_ready),
      .o_Frame_Err (frame_err),
      .o_Overrun   (overrun),
      .o_RX_Busy   (rx_busy),
      .o_Count     (count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // pop_at_stop raises rx_ready for exactly the stop-sample cycle
   task automatic send_byte(input logic [7:0] b, input logic stop, input logic pop_at_stop);
      rx_serial = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         tick(CPB);
      end
      rx_serial = stop;
      for (int i = 0; i < CPB; i++) begin
         tick(1);
         if (pop_at_stop && i == 5) rx_ready = 1'b1;
         if (i == 6) rx_ready = 1'b0;
      end
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check_eq({tag, "_valid"}, rx_valid, 1);
      check_eq({tag, "_byte"}, rx_byte, exp);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      rx_serial = 1'b1;
      rx_ready  = 1'b0;
      tick(3);
      rst = 1'b0;

      check_eq("rst_valid", rx_valid, 0);
      check_eq("rst_count", count, 0);
      check_eq("rst_byte", rx_byte, 0);
      check_eq("rst_busy", rx_busy, 0);
      check_eq("rst_ferr", frame_err, 0);
      check_eq("rst_ovr", overrun, 0);
      tick(2);

      // 1: single frame then pop
      send_byte(8'h55, 1'b1, 1'b0);
      check_eq("t1_valid", rx_valid, 1);
      check_eq("t1_byte", rx_byte, 8'h55);
      check_eq("t1_count", count, 1);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check_eq("t1_pop_valid", rx_valid, 0);
      check_eq("t1_pop_count", count, 0);
      tick(3);

      // 2: glitch rejection
      fe_base = fe_cnt;
      ov_base = ov_cnt;
      rx_serial = 1'b0;
      tick(2);
      rx_serial = 1'b1;
      tick(2);
      check_eq("t2_busy_seen", rx_busy, 1);
      for (int i = 0; i < 6 && rx_busy; i++) tick(1);
      check_eq("t2_busy_fall", rx_busy, 0);
      check_eq("t2_count", count, 0);
      check_eq("t2_pulses", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);
      tick(4);

      // 3: framing error, line held low, recovery
      fe_base = fe_cnt;
      send_byte(8'hA3, 1'b0, 1'b0);
      tick(20);
      check_eq("t3_break_busy", rx_busy, 1);
      check_eq("t3_ferr_cnt", fe_cnt - fe_base, 1);
      check_eq("t3_count", count, 0);
      rx_serial = 1'b1;
      tick(5);
      check_eq("t3_idle", rx_busy, 0);
      send_byte(8'h3C, 1'b1, 1'b0);
      check_eq("t3_ferr_after", fe_cnt - fe_base, 1);
      check_eq("t3_count2", count, 1);
      pop_expect("t3_pop", 8'h3C);
      tick(3);

      // 4: overrun and pointer wrap
      ov_base = ov_cnt;
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
      check_eq("t4_count_full", count, 4);
      check_eq("t4_ovr_cnt", ov_cnt - ov_base, 1);
      pop_expect("t4_pop1", 8'h01);
      pop_expect("t4_pop2", 8'h02);
      pop_expect("t4_pop3", 8'h03);
      pop_expect("t4_pop4", 8'h04);
      check_eq("t4_empty", rx_valid, 0);
      for (int i = 6; i <= 9; i++) send_byte(8'(i), 1'b1, 1'b0);
      check_eq("t4_count_wrap", count, 4);
      pop_expect("t4_pop6", 8'h06);
      pop_expect("t4_pop7", 8'h07);
      pop_expect("t4_pop8", 8'h08);
      pop_expect("t4_pop9", 8'h09);
      check_eq("t4_ovr_cnt2", ov_cnt - ov_base, 1);
      tick(3);

      // 5: full FIFO with pop in the stop-sample cycle
      ov_base = ov_cnt;
      send_byte(8'h11, 1'b1, 1'b0);
      send_byte(8'h22, 1'b1, 1'b0);
      send_byte(8'h33, 1'b1, 1'b0);
      send_byte(8'h44, 1'b1, 1'b0);
      check_eq("t5_full", count, 4);
      send_byte(8'h77, 1'b1, 1'b1);
      check_eq("t5_no_ovr", ov_cnt - ov_base, 0);
      check_eq("t5_count", count, 4);
      pop_expect("t5_pop22", 8'h22);
      pop_expect("t5_pop33", 8'h33);
      pop_expect("t5_pop44", 8'h44);
      pop_expect("t5_pop77", 8'h77);
      check_eq("t5_empty", count, 0);
      tick(3);

      // 6: reset during data bit 3 of 0xFF with a byte already queued
      send_byte(8'h5A, 1'b1, 1'b0);
      check_eq("t6_pre_count", count, 1);
      rx_serial = 1'b0;
      tick(CPB);
      rx_serial = 1'b1;
      tick(3 * CPB + 4);
      check_eq("t6_busy_data", rx_busy, 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_eq("t6_rst_valid", rx_valid, 0);
      check_eq("t6_rst_count", count, 0);
      check_eq("t6_rst_byte", rx_byte, 0);
      check_eq("t6_rst_busy", rx_busy, 0);
      check_eq("t6_rst_pulses", {frame_err, overrun}, 0);
      tick(4 * CPB);
      send_byte(8'h81, 1'b1, 1'b0);
      check_eq("t6_count", count, 1);
      pop_expect("t6_pop", 8'h81);

      check_eq("never_both_pulses", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
